// File: rtl/pool_scheduler_pkg.sv
// rtl/pool_scheduler_pkg.sv - shared pooling package: FSM encoding and frame constants
package pool_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLR    = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_e;

    localparam int DEF_M     = 12;
    localparam int DEF_P     = 3;
    localparam int FRAME_LEN = DEF_M * DEF_M;
    localparam int OUT_LEN   = (DEF_M / DEF_P) * (DEF_M / DEF_P);

    function automatic int frame_len(input int m);
        return m * m;
    endfunction

    function automatic int out_len(input int m, input int p);
        return (m / p) * (m / p);
    endfunction

endpackage

// File: rtl/pool_scheduler_if.sv
// rtl/pool_scheduler_if.sv - requester, pooler and result signals of the pool scheduler
interface pool_scheduler_if #(
    parameter int N    = 8,
    parameter int NREQ = 2
) ();
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]   src_valid;
    logic [NREQ*N-1:0] src_data;
    logic [NREQ-1:0]   src_ready;
    logic              pool_ce;
    logic              pool_rst_n;
    logic [N-1:0]      pool_data;
    logic [N-1:0]      pool_dout;
    logic              pool_valid;
    logic              pool_end;
    logic              out_valid;
    logic [N-1:0]      out_data;
    logic [IDW-1:0]    out_id;
    logic              out_last;
    logic              frame_done;
    logic              err_timeout;

    modport master (
        output src_valid, src_data, pool_dout, pool_valid, pool_end,
        input  src_ready, pool_ce, pool_rst_n, pool_data,
        input  out_valid, out_data, out_id, out_last, frame_done, err_timeout
    );

    modport slave (
        input  src_valid, src_data, pool_dout, pool_valid, pool_end,
        output src_ready, pool_ce, pool_rst_n, pool_data,
        output out_valid, out_data, out_id, out_last, frame_done, err_timeout
    );

endinterface

// File: rtl/pool_scheduler_rr_arbiter.sv
// rtl/pool_scheduler_rr_arbiter.sv - combinational round-robin arbiter, search starts at ptr
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant
);

    always_comb begin
        int   idx;
        logic found;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pool_scheduler.sv
// rtl/pool_scheduler.sv - time-shares one pooler between requesters, one whole frame per grant
import pool_scheduler_pkg::*;

module pool_scheduler #(
    parameter int N         = 8,
    parameter int M         = 12,
    parameter int P         = 3,
    parameter int NREQ      = 2,
    parameter int DRAIN_MAX = 64
) (
    input  logic            clk,
    input  logic            master_rst,
    pool_scheduler_if.slave bus
);

    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW   = $clog2(M * M + 1);
    localparam int DW   = $clog2(DRAIN_MAX + 1);
    localparam int FLEN = frame_len(M);
    localparam int OLEN = out_len(M, P);

    state_e          state_q, state_d;
    logic [IDW-1:0]  owner_q, owner_d, rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
    logic [DW-1:0]   drain_cnt_q, drain_cnt_d;
    logic            err_q, err_d;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            owner_valid, accept, fwd, drain_expired;
    logic [N-1:0]    owner_data;
    logic [NREQ-1:0] src_ready_c;
    logic            pool_ce_c, pool_rst_n_c, frame_done_c;
    logic [N-1:0]    pool_data_c;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req   (bus.src_valid),
        .ptr   (rr_ptr_q),
        .grant (grant)
    );

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) grant_idx = IDW'(i);
        end
    end

    assign owner_valid   = bus.src_valid[owner_q];
    assign owner_data    = bus.src_data[int'(owner_q) * N +: N];
    assign accept        = (state_q == STREAM) && owner_valid;
    assign drain_expired = (drain_cnt_q == DW'(DRAIN_MAX - 1));
    // results beyond the frame's quota are swallowed so out_last is the final beat seen
    assign fwd           = bus.pool_valid && ((state_q == STREAM) || (state_q == DRAIN))
                           && (out_cnt_q < CW'(OLEN));

    always_ff @(posedge clk or negedge master_rst) begin
        if (!master_rst) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            drain_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|bus.src_valid) state_d = CLR;
            CLR:     state_d = STREAM;
            STREAM:  if (accept && (in_cnt_q == CW'(FLEN - 1))) state_d = DRAIN;
            DRAIN:   if (bus.pool_end || drain_expired) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        in_cnt_d    = in_cnt_q;
        out_cnt_d   = out_cnt_q;
        drain_cnt_d = drain_cnt_q;
        err_d       = err_q;
        if ((state_q == IDLE) && (|bus.src_valid)) begin
            owner_d     = grant_idx;
            in_cnt_d    = '0;
            out_cnt_d   = '0;
            drain_cnt_d = '0;
        end
        if (accept) in_cnt_d = in_cnt_q + 1'b1;
        if (fwd)    out_cnt_d = out_cnt_q + 1'b1;
        if (state_q == DRAIN) begin
            drain_cnt_d = drain_cnt_q + 1'b1;
            if (!bus.pool_end && drain_expired) err_d = 1'b1;
        end
        if (state_q == DONE) begin
            rr_ptr_d = (owner_q == IDW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
        end
    end

    always_comb begin
        src_ready_c  = '0;
        pool_ce_c    = 1'b0;
        pool_rst_n_c = master_rst;
        pool_data_c  = '0;
        frame_done_c = 1'b0;
        case (state_q)
            CLR:    pool_rst_n_c = 1'b0;
            STREAM: begin
                src_ready_c[owner_q] = 1'b1;
                pool_ce_c            = owner_valid;
                pool_data_c          = owner_data;
            end
            DRAIN:  pool_ce_c    = 1'b1;
            DONE:   frame_done_c = 1'b1;
            default: ;
        endcase
    end

    assign bus.src_ready   = src_ready_c;
    assign bus.pool_ce     = pool_ce_c;
    assign bus.pool_rst_n  = pool_rst_n_c;
    assign bus.pool_data   = pool_data_c;
    assign bus.frame_done  = frame_done_c;
    assign bus.out_valid   = fwd && master_rst;
    assign bus.out_data    = bus.pool_dout;
    assign bus.out_id      = owner_q;
    assign bus.out_last    = fwd && master_rst && (out_cnt_q == CW'(OLEN - 1));
    assign bus.err_timeout = err_q;

endmodule

// File: doc/pool_scheduler.md
POOL_SCHEDULER -- requirements
Module: pool_scheduler

Interface
REQ-001 Parameters SHALL be: N, default 8, sample width; M, default 12, input matrix side; P, default 3, pooling window side (M divisible by P); NREQ, default 2, requester count; DRAIN_MAX, default 64, drain timeout in cycles.
REQ-002 Ports SHALL be: clk  in  1  single clock, rising edge.
REQ-003 master_rst  in  1  asynchronous active-low reset.
REQ-004 src_valid  in  NREQ  per-requester beat valid.
REQ-005 src_data  in  NREQ*N  per-requester sample, requester i at bits [i*N +: N].
REQ-006 src_ready  out  NREQ  per-requester beat accepted.
REQ-007 pool_ce  out  1  clock enable to the shared pooler.
REQ-008 pool_rst_n  out  1  active-low reset to the shared pooler.
REQ-009 pool_data  out  N  sample to the pooler.
REQ-010 pool_dout  in  N  pooler result; pool_valid  in  1  result valid; pool_end  in  1  pooler end of matrix.
REQ-011 out_valid  out  1; out_data  out  N; out_id  out  clog2(NREQ) owning requester; out_last  out  1  final result of a frame.
REQ-012 frame_done  out  1  one-cycle pulse per finished frame; err_timeout  out  1  sticky drain-timeout flag.

Function
REQ-013 The FSM SHALL have states IDLE, CLR, STREAM, DRAIN, DONE.
REQ-014 IDLE: when any src_valid is high, the block SHALL grant round-robin, searching from rr_ptr upward with wrap, latch owner, go to CLR; otherwise stay.
REQ-015 CLR: pool_rst_n SHALL be low for exactly one cycle, pool_ce low, then go to STREAM.
REQ-016 STREAM: src_ready[owner] SHALL be 1, all others 0; pool_ce = src_valid[owner]; pool_data = src_data[owner]; in_cnt increments per accepted beat.
REQ-017 Accepting beat M*M SHALL move the FSM to DRAIN; src_ready drops in the next cycle, so no beat M*M+1 is accepted.
REQ-018 DRAIN: pool_ce SHALL be 1 and pool_data 0 until pool_end is seen, then go to DONE; after DRAIN_MAX cycles without pool_end, set err_timeout and go to DONE.
REQ-019 DONE: frame_done SHALL pulse for one cycle, rr_ptr = owner+1 mod NREQ, return to IDLE; no grant in the DONE cycle.
REQ-020 out_valid SHALL equal pool_valid qualified by state STREAM or DRAIN, combinationally; out_data = pool_dout; out_id = owner.
REQ-021 out_cnt SHALL count out_valid beats per frame; out_last is high with the beat where out_cnt reaches (M/P)^2. Extra pool_valid beats after that are suppressed.
REQ-022 A pool_valid beat in the same cycle as pool_end SHALL still be forwarded.
REQ-023 Counters SHALL be sized clog2(M*M+1) and clog2(DRAIN_MAX+1) bits and SHALL clear on entry to CLR.
REQ-024 Requesters not granted SHALL be held off (ready low) and never dropped; grant changes only in IDLE.
REQ-025 Throughput: with continuous owner valid, one beat SHALL be accepted per cycle in STREAM.

Reset
REQ-026 On master_rst low, regardless of state: FSM = IDLE, rr_ptr = 0, owner = 0, all counters 0, err_timeout = 0, src_ready = 0, pool_ce = 0, pool_rst_n = 0, frame_done = 0. Outputs SHALL be gated so out_valid = 0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame with no frame_done; the first frame after release SHALL pass through CLR.
REQ-028 err_timeout SHALL clear only on reset.

Structure
REQ-029 State encoding and the derived constants FRAME_LEN = M*M and OUT_LEN = (M/P)^2 SHALL live in the shared pooling package.
REQ-030 One sub-module, rr_arbiter (NREQ requests, pointer in, one-hot grant out, combinational), is natural; the rest stays in pool_scheduler.

Verification
REQ-031 Single frame: req0 streams 144 beats back to back with M=12, P=3 -> pool_rst_n low for 1 cycle before the first accept; 16 out_valid with out_id=0; out_last on the 16th; one frame_done.
REQ-032 Contention: both requesters valid from reset -> req0 served first, then req1 (rr_ptr=1), then req0; frames never interleave.
REQ-033 Backpressure: owner valid toggles every cycle -> pool_ce mirrors the accepted beats; results are identical to the back-to-back case.
REQ-034 Overrun: owner holds valid after beat 144 -> only 144 accepts; src_ready low from the next cycle.
REQ-035 Timeout: pool_end tied low -> err_timeout set after 64 DRAIN cycles; frame_done pulses; the FSM returns to IDLE.
REQ-036 Mid-frame reset at beat 70 -> all outputs return to their reset values immediately; no frame_done; the next frame completes normally.
